// File: rtl/sd_pio_pkg.sv
// Shared constants for the SD bidirectional PIO: register addresses and edge modes.
package sd_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/sd_bidir_pio_if.sv
// Avalon-MM slave bus plus interrupt for the SD PIO.
interface sd_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/sd_pio_sync_edge.sv
// Three-flop pin synchroniser with reset-primed edge detection.
module sd_pio_sync_edge
  import sd_pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);
  logic [WIDTH-1:0] s1, s2, s3, raw;
  logic [1:0]       prime;
  logic             armed;

  // s3 only holds a genuine post-reset sample once three edges have passed,
  // so detection arms one edge after prime saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      prime <= 2'd0;
      armed <= 1'b0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      s3    <= s2;
      if (prime != 2'd2) prime <= prime + 2'd1;
      armed <= (prime == 2'd2);
    end
  end

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign raw = ~s2 & s3;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign raw = s2 ^ s3;
    end else begin : g_rise
      assign raw = s2 & ~s3;
    end
  endgenerate

  assign sync_in    = s2;
  assign edge_pulse = armed ? raw : '0;
endmodule

// File: rtl/sd_bidir_pio.sv
// Avalon-MM bidirectional PIO for SD DAT/CMD pins: direction, set/clear,
// synchronised input and maskable edge-capture interrupt.
module sd_bidir_pio
  import sd_pio_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               EDGE_TYPE = EDGE_RISE,
  parameter logic [WIDTH-1:0] DIR_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  sd_bidir_pio_if.slave   bus,
  inout  wire [WIDTH-1:0] bidir_port
);
  logic [WIDTH-1:0] data_out, dir, irq_mask, cap;
  logic [WIDTH-1:0] sync_in, edge_pulse, wd, clr;
  logic [31:0]      rd_nxt, rd_q;
  logic             wr;

  assign wr  = bus.chipselect && !bus.write_n;
  assign wd  = bus.writedata[WIDTH-1:0];
  assign clr = (wr && bus.address == ADDR_EDGE_CAP) ? wd : '0;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  sd_pio_sync_edge #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_sync (
    .clk       (clk),
    .rst       (reset),
    .pin       (bidir_port),
    .sync_in   (sync_in),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      ADDR_DATA:     rd_nxt[WIDTH-1:0] = sync_in;
      ADDR_DIR:      rd_nxt[WIDTH-1:0] = dir;
      ADDR_IRQ_MASK: rd_nxt[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_nxt[WIDTH-1:0] = cap;
      default:       rd_nxt = '0;
    endcase
  end

  // A new edge wins over a W1C clear hitting the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      dir      <= DIR_RESET;
      irq_mask <= '0;
      cap      <= '0;
      rd_q     <= '0;
    end else begin
      cap  <= (cap & ~clr) | edge_pulse;
      rd_q <= rd_nxt;
      if (wr) begin
        case (bus.address)
          ADDR_DATA:     data_out <= wd;
          ADDR_DIR:      dir      <= wd;
          ADDR_IRQ_MASK: irq_mask <= wd;
          ADDR_OUTSET:   data_out <= data_out | wd;
          ADDR_OUTCLR:   data_out <= data_out & ~wd;
          default:       ;
        endcase
      end
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = |(cap & irq_mask);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end
  endgenerate
endmodule

// File: tb/tb_sd_bidir_pio.sv
// Scoreboard bench for sd_bidir_pio: a pin-history reference model predicts
// readdata, irq and pin levels; a negedge monitor compares them.
module tb_sd_bidir_pio;
  import sd_pio_pkg::*;

  localparam int             W       = 4;
  localparam int             ET      = EDGE_RISE;
  localparam logic [W-1:0]   DIR_RST = 4'h4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rd_tag = 1'b0;
  logic [W-1:0] tb_val = 4'h9;

  int n_cmp = 0;
  int n_err = 0;

  sd_bidir_pio_if bus();
  wire [W-1:0] pins;

  // Reference state: register contents plus every pin level sampled since reset.
  logic [W-1:0] m_dir, m_out, m_mask, m_cap;
  logic [W-1:0] hist[$];
  logic [31:0]  exp_q[$];

  always #5 clk = ~clk;

  sd_bidir_pio #(.WIDTH(W), .EDGE_TYPE(ET), .DIR_RESET(DIR_RST)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .bidir_port(pins)
  );

  // The bench drives exactly the pins the model says are inputs.
  generate
    for (genvar i = 0; i < W; i++) begin : g_drv
      assign pins[i] = m_dir[i] ? 1'bz : tb_val[i];
    end
  endgenerate

  function automatic logic [W-1:0] edges_of(input logic [W-1:0] nw, input logic [W-1:0] old);
    case (ET)
      EDGE_RISE: return nw & ~old;
      EDGE_FALL: return ~nw & old;
      default:   return nw ^ old;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // At edge k the DATA register shows the sample from edge k-2, and an edge is
  // seen between samples k-2 and k-3 once both are real post-reset samples.
  always @(posedge clk or posedge reset) begin
    logic [W-1:0] pin_now, newer, older, ev, wd, clr, rdv;
    logic         wr;
    int           n;
    if (reset) begin
      m_dir  <= DIR_RST;
      m_out  <= '0;
      m_mask <= '0;
      m_cap  <= '0;
      hist.delete();
    end else begin
      n       = hist.size();
      pin_now = (m_dir & m_out) | (~m_dir & tb_val);
      newer   = (n >= 2) ? hist[n-2] : '0;
      older   = (n >= 3) ? hist[n-3] : '0;
      ev      = (n >= 3) ? edges_of(newer, older) : '0;
      wr      = bus.chipselect && !bus.write_n;
      wd      = bus.writedata[W-1:0];
      clr     = (wr && bus.address == 3'd3) ? wd : '0;
      m_cap  <= (m_cap & ~clr) | ev;
      if (wr) begin
        case (bus.address)
          3'd0: m_out  <= wd;
          3'd1: m_dir  <= wd;
          3'd2: m_mask <= wd;
          3'd4: m_out  <= m_out | wd;
          3'd5: m_out  <= m_out & ~wd;
          default: ;
        endcase
      end
      if (rd_tag) begin
        case (bus.address)
          3'd0:    rdv = newer;
          3'd1:    rdv = m_dir;
          3'd2:    rdv = m_mask;
          3'd3:    rdv = m_cap;
          default: rdv = '0;
        endcase
        exp_q.push_back({{(32-W){1'b0}}, rdv});
      end
      hist.push_back(pin_now);
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("readdata", bus.readdata, e);
    end
    check("irq", {31'd0, bus.irq}, {31'd0, |(m_cap & m_mask)});
    check("pins", {{(32-W){1'b0}}, pins},
          {{(32-W){1'b0}}, (m_dir & m_out) | (~m_dir & tb_val)});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    cyc(1);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1; rd_tag = 1'b1;
    cyc(1);
    rd_tag = 1'b0; bus.chipselect = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < 8; a++) rd(3'(a));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    cyc(n);
    reset = 1'b0;
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    #1;
    do_reset(3);
    cyc(5);
    rd_all();

    // Output drive, set and clear.
    wr(ADDR_DIR, 32'hF);
    wr(ADDR_DATA, 32'hA);
    cyc(3); rd(ADDR_DATA);
    wr(ADDR_OUTSET, 32'h1);
    cyc(3); rd(ADDR_DATA);
    wr(ADDR_OUTCLR, 32'h8);
    cyc(3); rd(ADDR_DATA);

    // Rising-edge capture on pin0 with mask 0x1.
    wr(ADDR_DIR, 32'h0);
    tb_val = 4'h0;
    wr(ADDR_IRQ_MASK, 32'h1);
    cyc(4);
    wr(ADDR_EDGE_CAP, 32'hF);
    cyc(2);
    tb_val = 4'h1;
    cyc(4); rd(ADDR_EDGE_CAP);
    tb_val = 4'h0;
    cyc(4); rd(ADDR_EDGE_CAP);

    // W1C racing a fresh rising edge, then a plain W1C.
    tb_val = 4'h1;
    cyc(2);
    wr(ADDR_EDGE_CAP, 32'h1);
    rd(ADDR_EDGE_CAP);
    cyc(2);
    wr(ADDR_EDGE_CAP, 32'h1);
    rd(ADDR_EDGE_CAP);
    cyc(2);

    // Pins high through reset: nothing captured; then toggle pin1 unmasked.
    tb_val = 4'hF;
    do_reset(3);
    cyc(6); rd(ADDR_EDGE_CAP);
    tb_val = 4'hD;
    cyc(3);
    tb_val = 4'hF;
    cyc(4); rd(ADDR_EDGE_CAP); rd(ADDR_DATA);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tb_val = W'($urandom);
      case ($urandom_range(0, 3))
        0: cyc(1);
        1: wr(3'($urandom_range(0, 7)), $urandom);
        default: rd(3'($urandom_range(0, 7)));
      endcase
    end
    cyc(2);
    rd_all();

    // Reset arriving mid-write with every pin an output.
    wr(ADDR_DIR, 32'hF);
    wr(ADDR_DATA, 32'h5);
    wr(ADDR_IRQ_MASK, 32'hF);
    cyc(2);
    tb_val = 4'hA;
    bus.address = ADDR_DATA; bus.writedata = 32'hA; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_readdata", bus.readdata, 32'd0);
    check("midrst_irq", {31'd0, bus.irq}, 32'd0);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    rd_all();
    cyc(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
